ex_issue_ctrl: RTL and testbench
================================

Name: ex_issue_ctrl

Overview:
- Execute-stage issue controller. Sits directly upstream of the ALU/divider/Hi-Lo/shifter execute unit.
- Accepts one decoded instruction (operands, funct, destination register) per handshake and drives the execute unit's operand and function inputs.
- Holds those inputs stable for the unit's fixed latency, or for the full multi-cycle divide, then captures the execute result.
- Presents the result to the EX/MEM side with a valid/ready handshake, stalling upstream while busy.

Parameters:
- ALU_LAT, 1, edges from issue until the execute unit's dataOut is valid for non-divide ops (≥1).
- DIV_CYCLES, 32, edges from issue until divide completes and Hi/Lo are written (≥1, ≤63).
- DIV_FUNCT, 6'd27, funct code treated as divide.
- NOP_FUNCT, 6'd0, funct driven to the execute unit when not issuing.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of current instruction
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  controller can accept
- in_dataA  in  32  operand A
- in_dataB  in  32  operand B / shift amount
- in_funct  in  6  function code
- in_rd  in  5  destination register
- alu_dataA  out  32  to execute unit dataA
- alu_dataB  out  32  to execute unit dataB
- alu_signal  out  6  to execute unit signal
- alu_dataOut  in  32  from execute unit dataOut
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  32  captured result
- out_rd  out  5  destination register
- out_wen  out  1  1 = register write, 0 = divide (Hi/Lo only)

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, in_ready=1. All other outputs 0, except alu_signal=NOP_FUNCT.
- States: IDLE, EXEC, DIV, DONE. 6-bit down-counter cnt.
- in_ready = (state==IDLE). Combinational from state only.
- IDLE, in_valid=1, flush=0 at an edge (accept):
  - Register alu_dataA/B ← in_dataA/B and alu_signal ← in_funct; latch in_rd.
  - in_funct==DIV_FUNCT → DIV, cnt←DIV_CYCLES-1.
  - Otherwise → EXEC, cnt←ALU_LAT-1.
- IDLE, flush=1: no accept; stay IDLE.
- EXEC/DIV: alu_dataA/B/signal held constant. cnt decrements each edge.
  - Edge where cnt==0, from EXEC: out_result←alu_dataOut, out_wen←1, out_rd←latched rd, out_valid←1, → DONE.
  - Edge where cnt==0, from DIV: out_result←0, out_wen←0, out_rd←latched rd, out_valid←1, → DONE.
  - Net latency: out_valid rises ALU_LAT (or DIV_CYCLES) edges after the accept edge.
- alu_signal returns to NOP_FUNCT on entry to DONE. alu_dataA/B keep their last values.
- DONE: out_* held stable while out_valid=1 and out_ready=0.
  - Edge with out_ready=1: out_valid←0, → IDLE.
  - No same-cycle re-accept: one bubble between instructions.
- flush in EXEC or DONE: → IDLE next edge, out_valid←0, alu_signal←NOP_FUNCT. Result is discarded.
- flush in DIV: divide is not abortable.
  - Stay in DIV and keep holding inputs until cnt==0.
  - Then → IDLE with out_valid never asserted.
  - A flag records the pending flush. A second flush has no further effect.
- flush and out_ready both high in DONE: flush wins; no transfer is counted.
- in_valid while not IDLE: ignored (in_ready=0). Upstream must hold its data.
- Reset asserted mid-EXEC/DIV/DONE: immediate return to reset values. The in-flight instruction is lost.

Test Plan:
- ADD (funct 6'd32), A=5, B=7, ALU_LAT=1, stub returns A+B → out_valid one edge after accept; out_result=12, out_wen=1, out_rd=in_rd=9; in_ready=0 until out_ready handshake.
- Backpressure: out_ready=0 for 5 cycles after SUB 10-3 → out_valid and out_result=7 held stable 5 cycles; second instruction held off (in_ready=0); accepted only after out_ready=1 plus IDLE cycle.
- DIVU (6'd27), A=100, B=7, DIV_CYCLES=32 → alu_signal=27 and operands stable for exactly 32 edges; out_valid at 32nd edge with out_wen=0, out_result=0; follow-up MFLO (6'd18) issued next returns stub value 14.
- flush at DIV cycle 10 → alu_signal stays 27 through cycle 32; out_valid never asserts; in_ready=1 the cycle after completion.
- flush in DONE with out_ready=1 same cycle → out_valid drops, no transfer counted; flush in IDLE with in_valid=1 → instruction not accepted.
- reset pulse low mid-DIV (cycle 15) → all outputs zero and alu_signal=NOP_FUNCT immediately (asynchronous); in_ready=1; next ADD completes normally.

Source files
------------

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: registers one instruction into the execute unit, holds it for ALU_LAT
// (or DIV_CYCLES) edges, then presents the result; in_ready stays low until out_ready drains it.
module ex_issue_ctrl #(
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [5:0]  DIV_FUNCT  = 6'd27,
  parameter logic [5:0]  NOP_FUNCT  = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dataA,
  input  logic [31:0] in_dataB,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_dataOut,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wen
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_DONE} state_t;

  localparam logic [5:0] ALU_CNT = 6'(ALU_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic [31:0] dataA_q, dataA_d;
  logic [31:0] dataB_q, dataB_d;
  logic [5:0]  signal_q, signal_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        wen_q, wen_d;
  logic        valid_q, valid_d;
  logic        accept;

  assign accept = (state_q == S_IDLE) && in_valid && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      S_IDLE: begin
        flush_pend_d = 1'b0;
        if (accept) begin
          if (in_funct == DIV_FUNCT) begin
            state_d = S_DIV;
            cnt_d   = DIV_CNT;
          end else begin
            state_d = S_EXEC;
            cnt_d   = ALU_CNT;
          end
        end
      end
      S_EXEC: begin
        if (flush)              state_d = S_IDLE;
        else if (cnt_q == 6'd0) state_d = S_DONE;
        else                    cnt_d   = cnt_q - 6'd1;
      end
      // The divider cannot be aborted: a flush only decides where we land once it finishes.
      S_DIV: begin
        if (cnt_q == 6'd0) begin
          state_d = (flush_pend_q || flush) ? S_IDLE : S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
          if (flush) flush_pend_d = 1'b1;
        end
      end
      S_DONE: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dataA_d  = dataA_q;
    dataB_d  = dataB_q;
    signal_d = signal_q;
    rd_d     = rd_q;
    result_d = result_q;
    out_rd_d = out_rd_q;
    wen_d    = wen_q;
    valid_d  = valid_q;
    if (accept) begin
      dataA_d  = in_dataA;
      dataB_d  = in_dataB;
      signal_d = in_funct;
      rd_d     = in_rd;
    end
    if ((state_q == S_EXEC || state_q == S_DIV) && state_d != state_q) signal_d = NOP_FUNCT;
    if (state_q == S_EXEC && state_d == S_DONE) begin
      result_d = alu_dataOut;
      wen_d    = 1'b1;
      out_rd_d = rd_q;
      valid_d  = 1'b1;
    end
    if (state_q == S_DIV && state_d == S_DONE) begin
      result_d = '0;
      wen_d    = 1'b0;
      out_rd_d = rd_q;
      valid_d  = 1'b1;
    end
    if (state_q == S_DONE && state_d == S_IDLE) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataA_q  <= '0;
      dataB_q  <= '0;
      signal_q <= NOP_FUNCT;
      rd_q     <= '0;
      result_q <= '0;
      out_rd_q <= '0;
      wen_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      dataA_q  <= dataA_d;
      dataB_q  <= dataB_d;
      signal_q <= signal_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      out_rd_q <= out_rd_d;
      wen_q    <= wen_d;
      valid_q  <= valid_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign alu_dataA  = dataA_q;
  assign alu_dataB  = dataB_q;
  assign alu_signal = signal_q;
  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_rd     = out_rd_q;
  assign out_wen    = wen_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: execute-unit stub with Hi/Lo, directed corner cases, then randomized traffic
// scored by a queue of expected results popped by an independent monitor.
module tb_ex_issue_ctrl;

  localparam int TB_ALU_LAT = 1;
  localparam int TB_DIV_CYC = 32;
  localparam logic [5:0] F_ADD = 6'd32, F_SUB = 6'd34, F_AND = 6'd36, F_OR = 6'd37;
  localparam logic [5:0] F_DIVU = 6'd27, F_MFLO = 6'd18, F_MFHI = 6'd16, F_NOP = 6'd0;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready, out_wen;
  logic [31:0] in_dataA, in_dataB, alu_dataA, alu_dataB, alu_dataOut, out_result;
  logic [5:0]  in_funct, alu_signal;
  logic [4:0]  in_rd, out_rd;

  ex_issue_ctrl #(.ALU_LAT(TB_ALU_LAT), .DIV_CYCLES(TB_DIV_CYC), .DIV_FUNCT(F_DIVU), .NOP_FUNCT(F_NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_dataA(in_dataA), .in_dataB(in_dataB), .in_funct(in_funct), .in_rd(in_rd),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal), .alu_dataOut(alu_dataOut),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Execute-unit stub: combinational ALU, Hi/Lo written while a divide is presented.
  logic [31:0] hi_s, lo_s;
  always_comb begin
    case (alu_signal)
      F_ADD:   alu_dataOut = alu_dataA + alu_dataB;
      F_SUB:   alu_dataOut = alu_dataA - alu_dataB;
      F_AND:   alu_dataOut = alu_dataA & alu_dataB;
      F_OR:    alu_dataOut = alu_dataA | alu_dataB;
      F_MFHI:  alu_dataOut = hi_s;
      F_MFLO:  alu_dataOut = lo_s;
      default: alu_dataOut = alu_dataA ^ alu_dataB;
    endcase
  end
  always @(posedge clk) begin
    if (alu_signal == F_DIVU && alu_dataB != 32'd0) begin
      hi_s <= alu_dataA % alu_dataB;
      lo_s <= alu_dataA / alu_dataB;
    end
  end

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    int          rise;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] m_hi, m_lo;
  int          errors, checks, xfer_cnt, exp_xfer;
  bit          prev_v, all_done, rnd_done;

  function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_MFHI:  return m_hi;
      F_MFLO:  return m_lo;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic reset_checks(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_result"}, out_result, 32'd0);
    chk({tag, "_out_rd"}, 32'(out_rd), 32'd0);
    chk1({tag, "_out_wen"}, out_wen, 1'b0);
    chk({tag, "_alu_dataA"}, alu_dataA, 32'd0);
    chk({tag, "_alu_dataB"}, alu_dataB, 32'd0);
    chk({tag, "_alu_signal"}, 32'(alu_signal), 32'(F_NOP));
  endtask

  // Call just after a negedge; holds in_valid until the accepting edge, returns 1ns after it.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input bit want_out, output int acc);
    bit   r, ok;
    exp_t e;
    ok = 1'b0;
    acc = -1;
    in_valid = 1'b1; in_funct = f; in_dataA = a; in_dataB = b; in_rd = rd;
    for (int i = 0; i < 400 && !ok; i++) begin
      r = in_ready;
      @(posedge clk); #1;
      if (r) ok = 1'b1;
      else @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_accept: funct %0d not accepted within 400 cycles, in_ready=%0b", f, in_ready);
    end else begin
      acc = cyc;
      e.rd = rd;
      if (f == F_DIVU) begin
        e.res = 32'd0; e.wen = 1'b0; e.rise = acc + TB_DIV_CYC;
        m_hi = a % b; m_lo = a / b;
      end else begin
        e.res = ref_alu(f, a, b); e.wen = 1'b1; e.rise = acc + TB_ALU_LAT;
      end
      if (want_out) begin
        exp_q.push_back(e);
        exp_xfer++;
      end
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  logic [5:0] flist [7] = '{F_ADD, F_SUB, F_AND, F_OR, F_DIVU, F_MFLO, F_MFHI};

  initial begin
    int acc, acc2;
    logic [5:0] f;
    logic [31:0] a, b;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_dataA = '0; in_dataB = '0; in_funct = '0; in_rd = '0;
    fork
      // Monitor: pops on each rising out_valid, checks hold while valid, counts transfers.
      begin
        while (!all_done) begin
          @(negedge clk); #2;
          if (!reset) prev_v = 1'b0;
          else begin
            if (out_valid) begin
              if (!prev_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_valid: out_valid=1 result 0x%0h with nothing expected (cycle %0d)", out_result, cyc);
                end else begin
                  cur = exp_q.pop_front();
                  if (out_result !== cur.res || out_rd !== cur.rd || out_wen !== cur.wen || cyc != cur.rise) begin
                    errors++;
                    $display("FAIL result: got res=0x%0h rd=%0d wen=%0b cycle=%0d, expected res=0x%0h rd=%0d wen=%0b cycle=%0d",
                             out_result, out_rd, out_wen, cyc, cur.res, cur.rd, cur.wen, cur.rise);
                  end
                end
              end else begin
                checks++;
                if (out_result !== cur.res || out_rd !== cur.rd || out_wen !== cur.wen) begin
                  errors++;
                  $display("FAIL hold_stable: got res=0x%0h rd=%0d wen=%0b, expected res=0x%0h rd=%0d wen=%0b",
                           out_result, out_rd, out_wen, cur.res, cur.rd, cur.wen);
                end
              end
              if (out_ready && !flush) xfer_cnt++;
            end
            prev_v = out_valid;
          end
        end
      end
      begin
        for (int t = 0; t < 50000 && !all_done; t++) @(negedge clk);
        if (!all_done) begin
          checks++; errors++;
          $display("FAIL watchdog: sequence did not complete within 50000 cycles");
          summary();
          $finish;
        end
      end
      begin
        #12;
        reset_checks("reset_state");
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // ADD 5+7 with late out_ready
        issue(F_ADD, 32'd5, 32'd7, 5'd9, 1'b1, acc);
        @(negedge clk); chk1("add_busy_in_ready", in_ready, 1'b0);
        @(negedge clk); chk1("add_hold_in_ready", in_ready, 1'b0); out_ready = 1'b1;
        @(negedge clk); chk1("add_idle_in_ready", in_ready, 1'b1); out_ready = 1'b0;

        // SUB 10-3 under backpressure, second instruction waiting
        issue(F_SUB, 32'd10, 32'd3, 5'd4, 1'b1, acc);
        @(negedge clk);
        in_valid = 1'b1; in_funct = F_ADD; in_dataA = 32'd1; in_dataB = 32'd2; in_rd = 5'd6;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk1("bp_out_valid", out_valid, 1'b1);
          chk("bp_out_result", out_result, 32'd7);
          chk1("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk); chk1("bp_idle_in_ready", in_ready, 1'b1);
        issue(F_ADD, 32'd1, 32'd2, 5'd6, 1'b1, acc2);
        chk("bp_accept_cycle", 32'(acc2), 32'(acc + 7));
        repeat (2) @(negedge clk);

        // DIVU 100/7 then MFLO
        issue(F_DIVU, 32'd100, 32'd7, 5'd3, 1'b1, acc);
        for (int i = 0; i < TB_DIV_CYC; i++) begin
          @(negedge clk);
          chk("div_signal", 32'(alu_signal), 32'(F_DIVU));
          chk("div_dataA", alu_dataA, 32'd100);
          chk("div_dataB", alu_dataB, 32'd7);
        end
        chk1("div_last_in_ready", in_ready, 1'b0);
        @(negedge clk); chk("div_done_signal", 32'(alu_signal), 32'(F_NOP));
        issue(F_MFLO, 32'd0, 32'd0, 5'd12, 1'b1, acc);
        chk("mflo_model", m_lo, 32'd14);
        repeat (2) @(negedge clk);

        // DIVU flushed at cycle 10, and again at 20
        issue(F_DIVU, 32'd81, 32'd9, 5'd5, 1'b0, acc);
        for (int i = 0; i < TB_DIV_CYC; i++) begin
          @(negedge clk);
          chk("divflush_signal", 32'(alu_signal), 32'(F_DIVU));
          flush = (i == 10 || i == 20);
        end
        chk1("divflush_last_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk1("divflush_in_ready", in_ready, 1'b1);
        chk1("divflush_out_valid", out_valid, 1'b0);
        chk("divflush_signal_nop", 32'(alu_signal), 32'(F_NOP));

        // flush and out_ready together in DONE
        out_ready = 1'b0;
        @(negedge clk);
        issue(F_ADD, 32'd20, 32'd22, 5'd7, 1'b1, acc);
        @(negedge clk); @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        exp_xfer--;
        chk1("flushdone_out_valid", out_valid, 1'b0);
        chk1("flushdone_in_ready", in_ready, 1'b1);

        // flush in IDLE blocks acceptance
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_funct = F_ADD; in_dataA = 32'd3; in_dataB = 32'd4; in_rd = 5'd1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk1("flushidle_in_ready", in_ready, 1'b1);
        chk("flushidle_signal", 32'(alu_signal), 32'(F_NOP));

        // flush in EXEC discards the result
        out_ready = 1'b1;
        @(negedge clk);
        issue(F_SUB, 32'd9, 32'd4, 5'd8, 1'b0, acc);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk1("flushexec_out_valid", out_valid, 1'b0);
        chk1("flushexec_in_ready", in_ready, 1'b1);
        chk("flushexec_signal", 32'(alu_signal), 32'(F_NOP));
        repeat (3) @(negedge clk);

        // asynchronous reset mid-divide
        issue(F_DIVU, 32'd50, 32'd5, 5'd2, 1'b0, acc);
        repeat (15) @(posedge clk);
        #3 reset = 1'b0;
        #1 reset_checks("reset_mid_div");
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        issue(F_ADD, 32'd40, 32'd2, 5'd11, 1'b1, acc);
        repeat (3) @(negedge clk);

        // randomized traffic with random backpressure
        fork
          begin
            for (int n = 0; n < 60; n++) begin
              repeat ($urandom_range(1, 3)) @(negedge clk);
              f = flist[$urandom_range(0, 6)];
              a = $urandom;
              b = (f == F_DIVU) ? 32'($urandom_range(1, 50000)) : $urandom;
              issue(f, a, b, 5'($urandom_range(0, 31)), 1'b1, acc);
            end
            for (int k = 0; k < 600 && (exp_q.size() != 0 || out_valid); k++) @(negedge clk);
            rnd_done = 1'b1;
          end
          begin
            while (!rnd_done) begin
              @(negedge clk);
              out_ready = ($urandom_range(0, 3) != 0);
            end
          end
        join
        @(negedge clk);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk1("drain_out_valid", out_valid, 1'b0);
        chk("xfer_count", 32'(xfer_cnt), 32'(exp_xfer));
        all_done = 1'b1;
      end
    join
    summary();
    $finish;
  end

endmodule
